// File: rtl/fetch_ctrl_if.sv
// Fetch bus bundle: instruction-memory port, branch redirect input and the
// valid/ready handshake toward decode. The master side is the fetch sequencer.
interface fetch_ctrl_if #(
   parameter int XLEN = 64
);
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_instr;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   logic            out_ready;

   modport master (
      output imem_addr, out_valid, out_instr, out_pc,
      input  imem_instr, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_instr, out_pc,
      output imem_instr, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the PC, reads the combinational
// instruction memory every cycle, buffers {pc, instr} pairs in a small FIFO
// and presents the head to decode. Redirects flush the buffer and reload the
// PC; fetching past the end of instruction memory parks the sequencer in
// HALT_OOB until the next redirect or reset.
module fetch_ctrl #(
   parameter int              XLEN       = 64,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2,
   parameter int              IMEM_AW    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         fetch_en,
   fetch_ctrl_if.master bus,
   output logic         align_err,
   output logic         oob,
   output logic [31:0]  fetch_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      RUN      = 1'b0,
      HALT_OOB = 1'b1
   } state_t;

   // Control state
   state_t           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             align_err_q, align_err_d;
   logic [31:0]      fetch_cnt_q, fetch_cnt_d;

   // FIFO payload (data only, never reset)
   logic [31:0]      instr_q [FIFO_DEPTH];
   logic [31:0]      instr_d [FIFO_DEPTH];
   logic [XLEN-1:0]  epc_q   [FIFO_DEPTH];
   logic [XLEN-1:0]  epc_d   [FIFO_DEPTH];

   logic empty;
   logic full;
   logic in_range;
   logic pop;
   logic push;
   logic fetch_try;

   // Buffer status and the push/pop qualifiers for this cycle.
   always_comb begin
      empty     = (cnt_q == '0);
      full      = (cnt_q == DEPTH_C);
      // Word index below 2^IMEM_AW <=> no bits set above the index field.
      in_range  = (pc_q[XLEN-1:IMEM_AW+2] == '0);
      pop       = !empty && bus.out_ready;
      fetch_try = (state_q == RUN) && fetch_en && !bus.redirect_valid;
      push      = fetch_try && in_range && (!full || pop);
   end

   // Next-state logic: redirect overrides everything else.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      align_err_d = 1'b0;
      fetch_cnt_d = fetch_cnt_q;
      instr_d     = instr_q;
      epc_d       = epc_q;

      if (bus.redirect_valid) begin
         // Any pop this cycle is consumed by decode and then flushed with the rest.
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         cnt_d       = '0;
         pc_d        = {bus.redirect_pc[XLEN-1:2], 2'b00};
         align_err_d = (bus.redirect_pc[1:0] != 2'b00);
         state_d     = RUN;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = bus.imem_instr;
            epc_d[wr_ptr_q]   = pc_q;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            pc_d              = pc_q + XLEN'(4);
            fetch_cnt_d       = fetch_cnt_q + 32'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
         // Trying to fetch past the end of memory parks the sequencer; pc holds.
         if (fetch_try && !in_range) begin
            state_d = HALT_OOB;
         end
      end
   end

   // Control registers with synchronous reset; also the FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         align_err_q <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         align_err_q <= align_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // FIFO payload storage; validity is tracked entirely by the control registers.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      epc_q   <= epc_d;
   end

   // Outputs: head of the FIFO is zeroed while empty so decode never sees stale data.
   always_comb begin
      bus.imem_addr = pc_q;
      bus.out_valid = !empty;
      bus.out_instr = empty ? 32'd0 : instr_q[rd_ptr_q];
      bus.out_pc    = empty ? '0    : epc_q[rd_ptr_q];
      align_err     = align_err_q;
      oob           = (state_q == HALT_OOB);
      fetch_cnt     = fetch_cnt_q;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by randomized traffic,
// all checked each cycle against a queue-based behavioural model.
module tb_fetch_ctrl;

   localparam int          XLEN       = 64;
   localparam logic [63:0] RESET_PC   = 64'h0;
   localparam int          FIFO_DEPTH = 2;
   localparam int          IMEM_AW    = 8;
   localparam int          IMEM_WORDS = 1 << IMEM_AW;

   logic        clk = 1'b0;
   logic        rst;
   logic        fen;
   logic        align_err;
   logic        oob;
   logic [31:0] fetch_cnt;

   logic [31:0] imem [IMEM_WORDS];

   int total = 0;
   int bad   = 0;

   fetch_ctrl_if #(.XLEN(XLEN)) bus ();

   fetch_ctrl #(
      .XLEN      (XLEN),
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(FIFO_DEPTH),
      .IMEM_AW   (IMEM_AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .fetch_en (fen),
      .bus      (bus),
      .align_err(align_err),
      .oob      (oob),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory.
   assign bus.imem_instr = imem[bus.imem_addr[IMEM_AW+1:2]];

   // Reference model state
   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        q[$];
   logic [63:0] m_pc    = RESET_PC;
   logic        m_halt  = 1'b0;
   logic        m_align = 1'b0;
   logic [31:0] m_cnt   = 32'd0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the specified behaviour.
   task automatic model_step();
      ent_t e;
      if (rst) begin
         q.delete();
         m_pc = RESET_PC; m_halt = 1'b0; m_align = 1'b0; m_cnt = 32'd0;
      end else if (bus.redirect_valid) begin
         q.delete();
         m_pc    = {bus.redirect_pc[63:2], 2'b00};
         m_align = (bus.redirect_pc[1:0] != 2'b00);
         m_halt  = 1'b0;
      end else begin
         m_align = 1'b0;
         if (q.size() != 0 && bus.out_ready) e = q.pop_front();
         if (!m_halt && fen) begin
            if ((m_pc >> 2) >= 64'(IMEM_WORDS)) begin
               m_halt = 1'b1;
            end else if (q.size() < FIFO_DEPTH) begin
               e.pc    = m_pc;
               e.instr = imem[m_pc[IMEM_AW+1:2]];
               q.push_back(e);
               m_pc  = m_pc + 64'd4;
               m_cnt = m_cnt + 32'd1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("out_pc",    bus.out_pc, (q.size() != 0) ? q[0].pc : 64'd0);
      chk("out_instr", 64'(bus.out_instr), (q.size() != 0) ? 64'(q[0].instr) : 64'd0);
      chk("align_err", 64'(align_err), 64'(m_align));
      chk("oob",       64'(oob), 64'(m_halt));
      chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
   endtask

   task automatic cycle(input logic r, input logic f, input logic rdy,
                        input logic rv, input logic [63:0] rp);
      rst                = r;
      fen                = f;
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rp;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic        r, f, rdy, rv;
      logic [63:0] rp;
      int          sel;

      for (int i = 0; i < IMEM_WORDS; i++) imem[i] = $urandom;

      // Reset, then streaming with decode always ready.
      cycle(1, 0, 0, 0, 0);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_cnt",   64'(fetch_cnt), 64'd0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0);
      chk("cnt_after5", 64'(fetch_cnt), 64'd5);

      // Decode stalled: only FIFO_DEPTH pushes, head held stable.
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);
      chk("stall_pc",   bus.imem_addr, 64'd8);
      chk("stall_head", bus.out_pc, 64'd0);
      chk("stall_cnt",  64'(fetch_cnt), 64'(FIFO_DEPTH));
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);

      // Redirect with a full FIFO flushes it.
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 1, 64'h10);
      chk("redir_flush", 64'(bus.out_valid), 64'd0);
      cycle(0, 1, 0, 0, 0);
      chk("redir_head0", bus.out_pc, 64'h10);
      cycle(0, 1, 1, 0, 0);
      chk("redir_head1", bus.out_pc, 64'h14);

      // Misaligned redirect target.
      cycle(0, 1, 1, 1, 64'h13);
      chk("align_set", 64'(align_err), 64'd1);
      chk("align_pc",  bus.imem_addr, 64'h10);
      cycle(0, 1, 1, 0, 0);
      chk("align_clr", 64'(align_err), 64'd0);

      // Run off the end of memory, drain, then recover with a redirect.
      cycle(0, 1, 1, 1, 64'h3F0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
      chk("oob_set",   64'(oob), 64'd1);
      chk("oob_drain", bus.out_pc, 64'h3FC);
      cycle(0, 1, 1, 0, 0);
      chk("oob_empty", 64'(bus.out_valid), 64'd0);
      cycle(0, 1, 1, 1, 64'h0);
      chk("oob_clr",   64'(oob), 64'd0);
      cycle(0, 1, 1, 0, 0);
      chk("oob_restart", bus.out_pc, 64'h0);

      // Reset mid-stream with a full FIFO.
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      chk("mrst_valid", 64'(bus.out_valid), 64'd0);
      chk("mrst_cnt",   64'(fetch_cnt), 64'd0);
      cycle(0, 1, 1, 0, 0);
      chk("mrst_head",  bus.out_pc, RESET_PC);

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         r   = ($urandom_range(0, 299) == 0);
         f   = ($urandom_range(0, 9) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         rv  = ($urandom_range(0, 19) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 6)       rp = 64'($urandom_range(0, IMEM_WORDS - 1)) << 2;
         else if (sel < 8)  rp = 64'($urandom_range(0, 4 * IMEM_WORDS - 1));
         else if (sel == 8) rp = 64'h3E0 + 64'($urandom_range(0, 31));
         else               rp = {32'($urandom), 32'($urandom)};
         cycle(r, f, rdy, rv, rp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
